// File: rtl/baby_ram_arbiter.sv
// ---------------------------------------------------------------------------
// baby_ram_arbiter
//
// Shares the single store RAM between the Baby CPU core and a host
// loader/debug port. Each requester has a req/gnt handshake. One access is
// issued per cycle, and issues may follow each other back to back. Read
// returns carry an owner tag, so each result goes back to the requester that
// asked for it, in issue order.
//
// Arbitration order, highest first:
//   1. host lock: only the host is granted
//   2. host starved for STARVE_MAX cycles
//   3. CPU
//   4. host
//
// Optional feature (macro BABY_ARB_CONFLICT_CNT_EN):
//   Adds conflict_cnt_o[7:0]. It is a saturating count of cycles in which
//   both requesters asked while the host lock was off.
//
// Ports:
//   fpgaGlobalClock, reset_i      : clock (rising edge), async active-low reset
//   cpu_req_i/we/addr/wdata       : CPU request
//   cpu_gnt_o/rvalid_o/rdata_o    : CPU grant and read return
//   host_req_i/we/addr/wdata      : host request
//   host_gnt_o/rvalid_o/rdata_o   : host grant and read return
//   host_lock_i                   : host-exclusive mode
//   ram_addr_o/data_o/rw_en_o     : registered RAM pins
//   ram_data_i                    : RAM read data
//   busy_o                        : access driven or read in flight
// ---------------------------------------------------------------------------
module baby_ram_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              fpgaGlobalClock,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              host_lock_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_rw_en_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              busy_o
`ifdef BABY_ARB_CONFLICT_CNT_EN
  ,
  output logic [7:0]        conflict_cnt_o
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              w_cpu_gnt;
  logic              w_host_gnt;
  logic              w_any_gnt;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  logic [3:0]        r_starve;
  logic              r_issue_v;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_ram_rw_en;
  logic [RD_LAT:0]   r_tag_v;
  logic [RD_LAT:0]   r_tag_h;
  logic              r_cpu_rvalid;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  // Grant selection from the current requests and the starvation count.
  // While reset is asserted, no grant is shown, so the outputs read all-zero.
  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    if (!reset_i) begin
      w_cpu_gnt  = 1'b0;
      w_host_gnt = 1'b0;
    end else if (host_lock_i) begin
      w_host_gnt = host_req_i;
    end else if (host_req_i && (r_starve == STARVE_LIM)) begin
      w_host_gnt = 1'b1;
    end else if (cpu_req_i) begin
      w_cpu_gnt = 1'b1;
    end else begin
      w_host_gnt = host_req_i;
    end
  end

  assign w_any_gnt   = w_cpu_gnt | w_host_gnt;
  assign w_sel_we    = w_host_gnt ? host_we_i    : cpu_we_i;
  assign w_sel_addr  = w_host_gnt ? host_addr_i  : cpu_addr_i;
  assign w_sel_wdata = w_host_gnt ? host_wdata_i : cpu_wdata_i;

  // Starvation counter: counts consecutive denied host-request cycles.
  always_ff @(posedge fpgaGlobalClock or negedge reset_i) begin
    if (!reset_i) begin
      r_starve <= 4'd0;
    end else if (host_req_i && !w_host_gnt) begin
      if (r_starve != STARVE_LIM) r_starve <= r_starve + 4'd1;
      else                        r_starve <= r_starve;
    end else begin
      r_starve <= 4'd0;
    end
  end

  // Issue stage: register the granted access onto the RAM pins.
  // The address and data hold their last values when there is no grant.
  always_ff @(posedge fpgaGlobalClock or negedge reset_i) begin
    if (!reset_i) begin
      r_issue_v   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_ram_rw_en <= 1'b0;
    end else begin
      r_issue_v <= w_any_gnt;
      if (w_any_gnt) begin
        r_ram_addr  <= w_sel_addr;
        r_ram_rw_en <= w_sel_we;
        if (w_sel_we) r_ram_data <= w_sel_wdata;
        else          r_ram_data <= r_ram_data;
      end else begin
        r_ram_rw_en <= 1'b0;
      end
    end
  end

  // Owner-tag pipeline. Stage k is valid during cycle N+1+k, so the last
  // stage lines up with the cycle whose ram_data_i belongs to that read.
  always_ff @(posedge fpgaGlobalClock or negedge reset_i) begin
    if (!reset_i) begin
      r_tag_v <= '0;
      r_tag_h <= '0;
    end else begin
      r_tag_v <= {r_tag_v[RD_LAT-1:0], w_any_gnt & ~w_sel_we};
      r_tag_h <= {r_tag_h[RD_LAT-1:0], w_host_gnt};
    end
  end

  // Read return: capture RAM data into the owner's register and pulse its rvalid.
  always_ff @(posedge fpgaGlobalClock or negedge reset_i) begin
    if (!reset_i) begin
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_cpu_rdata   <= '0;
      r_host_rdata  <= '0;
    end else begin
      r_cpu_rvalid  <= r_tag_v[RD_LAT] & ~r_tag_h[RD_LAT];
      r_host_rvalid <= r_tag_v[RD_LAT] &  r_tag_h[RD_LAT];
      if (r_tag_v[RD_LAT] && !r_tag_h[RD_LAT]) r_cpu_rdata <= ram_data_i;
      else                                     r_cpu_rdata <= r_cpu_rdata;
      if (r_tag_v[RD_LAT] && r_tag_h[RD_LAT])  r_host_rdata <= ram_data_i;
      else                                     r_host_rdata <= r_host_rdata;
    end
  end

`ifdef BABY_ARB_CONFLICT_CNT_EN
  logic [7:0] r_conflict;

  // Saturating count of cycles with unresolved CPU/host contention.
  always_ff @(posedge fpgaGlobalClock or negedge reset_i) begin
    if (!reset_i) begin
      r_conflict <= 8'd0;
    end else if (cpu_req_i && host_req_i && !host_lock_i && (r_conflict != 8'd255)) begin
      r_conflict <= r_conflict + 8'd1;
    end else begin
      r_conflict <= r_conflict;
    end
  end

  assign conflict_cnt_o = r_conflict;
`endif

  assign cpu_gnt_o     = w_cpu_gnt;
  assign host_gnt_o    = w_host_gnt;
  assign cpu_rvalid_o  = r_cpu_rvalid;
  assign host_rvalid_o = r_host_rvalid;
  assign cpu_rdata_o   = r_cpu_rdata;
  assign host_rdata_o  = r_host_rdata;
  assign ram_addr_o    = r_ram_addr;
  assign ram_data_o    = r_ram_data;
  assign ram_rw_en_o   = r_ram_rw_en;
  assign busy_o        = r_issue_v | (|r_tag_v);

endmodule

// File: tb/tb_baby_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_baby_ram_arbiter
//
// Scoreboard bench for baby_ram_arbiter.
//
// Each cycle, a reference model works out the expected grant from the
// arbitration rules. It also keeps its own memory image, updated in grant
// order. For every granted read it queues the expected owner, data and
// return cycle. A separate monitor pops that queue when the read return is
// due and compares it with the DUT.
//
// The external RAM is a simple behavioural model with one cycle of read
// latency.
// ---------------------------------------------------------------------------
module tb_baby_ram_arbiter;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              cpu_req_i, cpu_we_i, host_req_i, host_we_i, host_lock_i;
  logic [ADDR_W-1:0] cpu_addr_i, host_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i, host_wdata_i;
  logic              cpu_gnt_o, cpu_rvalid_o, host_gnt_o, host_rvalid_o;
  logic [DATA_W-1:0] cpu_rdata_o, host_rdata_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_data_o, ram_data_i;
  logic              ram_rw_en_o, busy_o;
`ifdef BABY_ARB_CONFLICT_CNT_EN
  logic [7:0]        conflict_cnt_o;
`endif

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  baby_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .fpgaGlobalClock(clk),
    .reset_i(reset_i),
    .cpu_req_i(cpu_req_i),
    .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_gnt_o(cpu_gnt_o),
    .cpu_rvalid_o(cpu_rvalid_o),
    .cpu_rdata_o(cpu_rdata_o),
    .host_req_i(host_req_i),
    .host_we_i(host_we_i),
    .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o),
    .host_lock_i(host_lock_i),
    .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o),
    .ram_rw_en_o(ram_rw_en_o),
    .ram_data_i(ram_data_i),
    .busy_o(busy_o)
`ifdef BABY_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // External RAM model: the write lands at the clock edge, and the read data
  // appears one cycle after its address.
  logic [DATA_W-1:0] ram_mem [32];
  logic [DATA_W-1:0] ram_rd;
  logic              ram_preload;

  always @(posedge clk) begin
    if (ram_preload) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= init_word(i);
    end else begin
      if (ram_rw_en_o) ram_mem[ram_addr_o] <= ram_data_o;
      ram_rd <= ram_mem[ram_addr_o];
    end
  end

  assign ram_data_i = ram_rd;

  // Reference model state
  typedef struct {
    bit          h;
    logic [31:0] d;
    int          due;
  } rd_t;

  rd_t         exp_q[$];
  logic [31:0] ref_mem [32];
  int          denied;
  bit          prev_v, prev_we;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;
  int          conf;

  // Model process: check grants, issue pins and busy, then apply the grant.
  initial begin
    bit exp_h, exp_c, busy_exp;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    denied = 0; prev_v = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_data = '0; conf = 0;
    forever begin
      @(negedge clk);
      if (!reset_i) begin
        check("rst_cpu_gnt",  64'(cpu_gnt_o),   64'd0);
        check("rst_host_gnt", 64'(host_gnt_o),  64'd0);
        check("rst_rw_en",    64'(ram_rw_en_o), 64'd0);
        check("rst_addr",     64'(ram_addr_o),  64'd0);
        check("rst_data",     64'(ram_data_o),  64'd0);
        check("rst_busy",     64'(busy_o),      64'd0);
`ifdef BABY_ARB_CONFLICT_CNT_EN
        check("rst_conflict", 64'(conflict_cnt_o), 64'd0);
`endif
        exp_q.delete();
        denied = 0; prev_v = 1'b0; prev_we = 1'b0; conf = 0;
      end else begin
        exp_h = 1'b0; exp_c = 1'b0;
        if (host_lock_i)                              exp_h = host_req_i;
        else if (host_req_i && denied >= STARVE_MAX)  exp_h = 1'b1;
        else if (cpu_req_i)                           exp_c = 1'b1;
        else                                          exp_h = host_req_i;
        check("cpu_gnt",  64'(cpu_gnt_o),  64'(exp_c));
        check("host_gnt", 64'(host_gnt_o), 64'(exp_h));
        check("rw_en", 64'(ram_rw_en_o), 64'(prev_v & prev_we));
        if (prev_v)             check("ram_addr", 64'(ram_addr_o), 64'(prev_addr));
        if (prev_v && prev_we)  check("ram_data", 64'(ram_data_o), 64'(prev_data));
        busy_exp = prev_v;
        foreach (exp_q[k]) if (cyc < exp_q[k].due) busy_exp = 1'b1;
        check("busy", 64'(busy_o), 64'(busy_exp));
`ifdef BABY_ARB_CONFLICT_CNT_EN
        check("conflict_cnt", 64'(conflict_cnt_o), 64'(conf));
        if (cpu_req_i && host_req_i && !host_lock_i && conf < 255) conf++;
`endif
        // Apply the expected grant to the model's memory image
        prev_v = exp_h | exp_c;
        if (exp_h) begin
          prev_we = host_we_i; prev_addr = host_addr_i; prev_data = host_wdata_i;
        end else begin
          prev_we = cpu_we_i;  prev_addr = cpu_addr_i;  prev_data = cpu_wdata_i;
        end
        if (prev_v) begin
          if (prev_we) ref_mem[prev_addr] = prev_data;
          else exp_q.push_back('{h: exp_h, d: ref_mem[prev_addr], due: cyc + 2 + RD_LAT});
        end
        if (host_req_i && !exp_h) denied = (denied < STARVE_MAX) ? denied + 1 : STARVE_MAX;
        else                      denied = 0;
      end
    end
  end

  // Monitor: compare read returns against the queue head when they fall due.
  initial begin
    rd_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_i) begin
        check("rst_cpu_rvalid",  64'(cpu_rvalid_o),  64'd0);
        check("rst_host_rvalid", 64'(host_rvalid_o), 64'd0);
        check("rst_cpu_rdata",   64'(cpu_rdata_o),   64'd0);
        check("rst_host_rdata",  64'(host_rdata_o),  64'd0);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missed_return cyc=%0d actual=none expected_due=%0d", cyc, e.due);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          check("cpu_rvalid",  64'(cpu_rvalid_o),  64'(!e.h));
          check("host_rvalid", 64'(host_rvalid_o), 64'(e.h));
          if (e.h) check("host_rdata", 64'(host_rdata_o), 64'(e.d));
          else     check("cpu_rdata",  64'(cpu_rdata_o),  64'(e.d));
        end else begin
          check("cpu_rvalid_idle",  64'(cpu_rvalid_o),  64'd0);
          check("host_rvalid_idle", 64'(host_rvalid_o), 64'd0);
        end
      end
    end
  end

  task automatic drive(bit cr, bit cw, logic [4:0] ca, logic [31:0] cd,
                       bit hr, bit hw, logic [4:0] ha, logic [31:0] hd, bit lk);
    cpu_req_i = cr;  cpu_we_i = cw;  cpu_addr_i = ca;  cpu_wdata_i = cd;
    host_req_i = hr; host_we_i = hw; host_addr_i = ha; host_wdata_i = hd;
    host_lock_i = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Stimulus
  initial begin
    reset_i = 1'b0; ram_preload = 1'b1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
    host_lock_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b1; ram_preload = 1'b0;
    idle(2);

    // Host-only write then read of addr 7
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd7, 32'd0, 1'b0);
    idle(4);

    // Contention: CPU x4, host x1, repeating
    for (int i = 0; i < 15; i++)
      drive(1'b1, 1'b0, 5'(i), 32'd0, 1'b1, 1'b0, 5'(31 - i), 32'd0, 1'b0);
    idle(4);

    // Host lock: the CPU is never granted
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b0, 5'(i), 32'd0, 1'b1, 1'b0, 5'(i + 10), 32'd0, 1'b1);
    idle(4);

    // Pipelined interleave: CPU read addr 1, then host read addr 2
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'h0000_0011, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd2, 32'h0000_0022, 1'b0);
    drive(1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0, 1'b0);
    idle(4);

    // Reset one cycle after a CPU read grant
    drive(1'b1, 1'b0, 5'd3, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    reset_i = 1'b0;
    idle(2);
    reset_i = 1'b1;
    idle(4);
    drive(1'b1, 1'b0, 5'd4, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(4);

`ifdef BABY_ARB_CONFLICT_CNT_EN
    // Saturation of the contention counter
    for (int i = 0; i < 300; i++)
      drive(1'b1, 1'b0, 5'(i), 32'd0, 1'b1, 1'b0, 5'(i), 32'd0, 1'b0);
    idle(2);
`endif

    // Randomized traffic on a small address window for read-after-write hits
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom),
            ($urandom_range(0, 9) == 0));

    idle(6);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baby_ram_arbiter.md
Name: baby_ram_arbiter

Overview:
- Shares the single 32x32 store RAM between the Baby CPU core and a host loader/debug port (program load, store readback while stopped).
- Sits between `main`'s RAM interface and the external RAM pins: `ram_addr_o`, `ram_data_o`, `ram_data_i`, `ram_rw_en_o`.
- Per-requester req/gnt handshake, pipelined issue, owner-tagged read returns.
- Starvation guard for the host; exclusive-host lock mode.

Parameters:
- ADDR_W, 5, RAM address width (32 words).
- DATA_W, 32, RAM word width.
- RD_LAT, 1, cycles from `ram_addr_o` valid to `ram_data_i` valid (1..3).
- STARVE_MAX, 4, consecutive denied host-request cycles before the host is forced a grant (1..15).

Ports:
- fpgaGlobalClock  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  CPU access request; hold with addr/we/wdata stable until granted.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  ADDR_W  CPU word address.
- cpu_wdata_i  in  DATA_W  CPU write data.
- cpu_gnt_o  out  1  CPU request accepted this cycle.
- cpu_rvalid_o  out  1  one-cycle pulse: cpu_rdata_o valid.
- cpu_rdata_o  out  DATA_W  CPU read data.
- host_req_i, host_we_i, host_addr_i, host_wdata_i  in  1/1/ADDR_W/DATA_W  host equivalents.
- host_gnt_o, host_rvalid_o, host_rdata_o  out  1/1/DATA_W  host equivalents.
- host_lock_i  in  1  1 = host-exclusive; CPU never granted.
- ram_addr_o  out  ADDR_W  RAM address (registered).
- ram_data_o  out  DATA_W  RAM write data (registered).
- ram_rw_en_o  out  1  1 = write strobe for the cycle (registered).
- ram_data_i  in  DATA_W  RAM read data.
- busy_o  out  1  access issued or read in flight.

Behaviour:
- Reset values (async assert, all zero):
  - `ram_addr_o`, `ram_data_o`, `ram_rw_en_o`.
  - Both `gnt`, both `rvalid`, both `rdata`.
  - `busy_o`, starvation counter.
  - Read-tag pipeline cleared; in-flight reads discarded, no `rvalid` afterwards.
- Grants are combinational from requests and registered state. At most one grant per cycle; one access issued per cycle; back-to-back accesses are allowed.
- Arbitration priority, evaluated each cycle:
  1. `host_lock_i=1`: host granted if `host_req_i`; `cpu_gnt_o=0`.
  2. Starvation counter == STARVE_MAX and `host_req_i`: host granted.
  3. `cpu_req_i`: CPU granted.
  4. `host_req_i`: host granted.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle `host_req_i=1` and the host is not granted.
  - Clears on any host grant, or when `host_req_i=0`.
- Issue timing:
  - Grant in cycle N → `ram_addr_o`, `ram_data_o` (writes only) and `ram_rw_en_o=we` registered, driven in cycle N+1.
  - No grant in a cycle → next cycle `ram_rw_en_o=0`; `ram_addr_o` and `ram_data_o` hold their last values.
- Read return:
  - Owner tag {valid, is_host} shifts through an (RD_LAT+1)-deep pipeline.
  - `ram_data_i` is sampled at the end of cycle N+1+RD_LAT.
  - The owner's `rdata_o` updates and `rvalid_o` pulses in cycle N+2+RD_LAT. Default RD_LAT=1: N+3.
  - Returns occur in issue order. Each `rdata_o` holds until that owner's next `rvalid`.
- Writes: no response pulse. A write is complete once issued in cycle N+1.
- Read-after-write to the same address granted in consecutive cycles returns the new data; the RAM is write-first by issue order.
- `busy_o`: 1 when an access is being driven this cycle or any read tag is valid.
- `host_lock_i` rising while a CPU read is in flight: that read still completes to the CPU. Lock only gates new grants.
- A requester dropping `req` before its grant is legal; nothing is issued for it.

Optional Feature:
- Macro: BABY_ARB_CONFLICT_CNT_EN.
- Defined:
  - Adds output `conflict_cnt_o[7:0]`, reset 0.
  - Increments, saturating at 255, in every cycle where `cpu_req_i & host_req_i & ~host_lock_i`.
- Undefined: port and counter absent. Arbitration is identical in both cases.

Test Plan:
- Host-only write then read: host writes 0xDEADBEEF to addr 7, then reads addr 7 → `ram_rw_en_o=1` with `ram_addr_o=7` in cycle N+1; read returns `host_rvalid_o` pulse with `host_rdata_o=0xDEADBEEF` at grant+3; `cpu_rvalid_o` stays 0.
- Contention, STARVE_MAX=4: `cpu_req_i` and `host_req_i` held high continuously → CPU granted cycles 0-3, host granted cycle 4, CPU cycle 5 onward. Pattern repeats every 5 cycles.
- Lock: `host_lock_i=1`, both requesting for 10 cycles → `cpu_gnt_o=0` throughout; host granted all 10 cycles.
- Pipelined interleave: CPU read addr 1 in cycle 0, host read addr 2 in cycle 1; RAM holds 0x11 at addr 1 and 0x22 at addr 2 → `cpu_rvalid_o` with 0x11 in cycle 3; `host_rvalid_o` with 0x22 in cycle 4.
- Reset mid-read: assert `reset_i=0` one cycle after a CPU read grant → all outputs 0 immediately; no `rvalid` after release; first post-reset grant behaves normally.
- With BABY_ARB_CONFLICT_CNT_EN: 300 contention cycles → `conflict_cnt_o` saturates at 255.
